// File: rtl/layer_ram_fill_ctrl_if.sv
// Bundle of request, response, cache and SDRAM burst signals for layer_ram_fill_ctrl.
// The master modport is the controller; the slave modport is its surroundings.
interface layer_ram_fill_ctrl_if #(
    parameter int ADDR_WIDTH_WORDS = 24,
    parameter int CACHE_DEPTH      = 32,
    parameter int MAX_LAYERS       = 32
);
    localparam int AW = ADDR_WIDTH_WORDS;
    localparam int LW = $clog2(MAX_LAYERS);
    localparam int CW = $clog2(CACHE_DEPTH);

    logic          req_valid;
    logic          req_ready;
    logic [LW-1:0] req_layer;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_data;
    logic [LW-1:0] cache_layer;
    logic [AW-1:0] cache_addr;
    logic          cache_hit;
    logic [15:0]   cache_rd_data;
    logic          cache_write_en;
    logic [15:0]   cache_wr_data;
    logic          sdram_rd_req;
    logic [AW-1:0] sdram_rd_addr;
    logic [CW:0]   sdram_rd_len;
    logic          sdram_rd_ack;
    logic          sdram_rd_valid;
    logic [15:0]   sdram_rd_data;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    modport master (
        input  req_valid, req_layer, req_addr, rsp_ready,
        input  cache_hit, cache_rd_data,
        input  sdram_rd_ack, sdram_rd_valid, sdram_rd_data,
        output req_ready, rsp_valid, rsp_data,
        output cache_layer, cache_addr, cache_write_en, cache_wr_data,
        output sdram_rd_req, sdram_rd_addr, sdram_rd_len,
        output hit_count, miss_count
    );

    modport slave (
        output req_valid, req_layer, req_addr, rsp_ready,
        output cache_hit, cache_rd_data,
        output sdram_rd_ack, sdram_rd_valid, sdram_rd_data,
        input  req_ready, rsp_valid, rsp_data,
        input  cache_layer, cache_addr, cache_write_en, cache_wr_data,
        input  sdram_rd_req, sdram_rd_addr, sdram_rd_len,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/layer_ram_fill_ctrl.sv
// Layer RAM cache requester: probes the cache per request, and on a miss fills a whole
// slot from one SDRAM burst before answering with the first word of that burst.
module layer_ram_fill_ctrl #(
    parameter int ADDR_WIDTH_WORDS = 24,
    parameter int CACHE_DEPTH      = 32,
    parameter int MAX_LAYERS       = 32
) (
    input logic                  clk,
    input logic                  rst,
    layer_ram_fill_ctrl_if.master bus
);
    localparam int AW = ADDR_WIDTH_WORDS;
    localparam int LW = $clog2(MAX_LAYERS);
    localparam int CW = $clog2(CACHE_DEPTH);
    localparam logic [CW:0] BURST_LEN = (CW+1)'(CACHE_DEPTH);
    localparam logic [CW:0] LAST_CNT  = (CW+1)'(CACHE_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REQ,
        FILL,
        RESPOND
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [LW-1:0] lay_q;
    logic [AW-1:0] base_q;
    logic [CW:0]   cnt;
    logic [15:0]   rsp_data_q;
    logic [15:0]   hit_q;
    logic [15:0]   miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A word arriving in the cycle rst is high belongs to an abandoned burst and must never be written.
    always_comb begin
        state_next         = state;
        bus.req_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.cache_layer    = '0;
        bus.cache_addr     = '0;
        bus.cache_write_en = 1'b0;
        bus.cache_wr_data  = '0;
        bus.sdram_rd_req   = 1'b0;
        bus.sdram_rd_addr  = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                bus.cache_layer = lay_q;
                bus.cache_addr  = base_q;
                state_next      = bus.cache_hit ? RESPOND : REQ;
            end
            REQ: begin
                bus.sdram_rd_req  = 1'b1;
                bus.sdram_rd_addr = base_q;
                if (bus.sdram_rd_ack) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                bus.cache_layer = lay_q;
                bus.cache_addr  = base_q + AW'(cnt);
                if (bus.sdram_rd_valid) begin
                    bus.cache_write_en = !rst;
                    bus.cache_wr_data  = bus.sdram_rd_data;
                    if (cnt == LAST_CNT) begin
                        state_next = RESPOND;
                    end
                end
            end
            RESPOND: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lay_q      <= '0;
            base_q     <= '0;
            cnt        <= '0;
            rsp_data_q <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lay_q  <= bus.req_layer;
                        base_q <= bus.req_addr;
                    end
                end
                LOOKUP: begin
                    if (bus.cache_hit) begin
                        rsp_data_q <= bus.cache_rd_data;
                        if (hit_q != 16'hFFFF) begin
                            hit_q <= hit_q + 16'd1;
                        end
                    end else if (miss_q != 16'hFFFF) begin
                        miss_q <= miss_q + 16'd1;
                    end
                end
                REQ: begin
                    cnt <= '0;
                end
                FILL: begin
                    if (bus.sdram_rd_valid) begin
                        if (cnt == '0) begin
                            rsp_data_q <= bus.sdram_rd_data;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_data     = rsp_data_q;
    assign bus.sdram_rd_len = BURST_LEN;
    assign bus.hit_count    = hit_q;
    assign bus.miss_count   = miss_q;
endmodule

// File: tb/tb_layer_ram_fill_ctrl.sv
// Randomized scoreboard bench for layer_ram_fill_ctrl: an emulated cache answers probes, and a
// word-level model of cache contents predicts hits, fill writes, responses and counters.
module tb_layer_ram_fill_ctrl;
    localparam int AW     = 24;
    localparam int DEPTH  = 32;
    localparam int LAYERS = 32;
    localparam int LW     = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    layer_ram_fill_ctrl_if #(.ADDR_WIDTH_WORDS(AW), .CACHE_DEPTH(DEPTH), .MAX_LAYERS(LAYERS)) bus ();

    layer_ram_fill_ctrl #(.ADDR_WIDTH_WORDS(AW), .CACHE_DEPTH(DEPTH), .MAX_LAYERS(LAYERS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [LW-1:0] layer;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rsp[$];
    logic [15:0] cache_mem [logic [LW+AW-1:0]];
    logic [15:0] model_mem [logic [LW+AW-1:0]];
    int          tests = 0;
    int          fails = 0;
    int          model_hits = 0;
    int          model_misses = 0;
    wr_t         mon_wr;
    logic        prev_wait = 1'b0;
    logic [15:0] prev_data = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Emulated cache: stores whatever the controller writes and answers probes combinationally.
    always @(negedge clk) begin
        if (bus.cache_write_en) begin
            cache_mem[{bus.cache_layer, bus.cache_addr}] = bus.cache_wr_data;
        end
        if (cache_mem.exists({bus.cache_layer, bus.cache_addr})) begin
            bus.cache_hit     = 1'b1;
            bus.cache_rd_data = cache_mem[{bus.cache_layer, bus.cache_addr}];
        end else begin
            bus.cache_hit     = 1'b0;
            bus.cache_rd_data = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            if (bus.cache_write_en) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_write", 32'(1), 32'(0));
                end else begin
                    mon_wr = exp_wr.pop_front();
                    checkOutput("wr_layer", 32'(bus.cache_layer), 32'(mon_wr.layer));
                    checkOutput("wr_addr", 32'(bus.cache_addr), 32'(mon_wr.addr));
                    checkOutput("wr_data", 32'(bus.cache_wr_data), 32'(mon_wr.data));
                end
            end
            if (bus.rsp_valid) begin
                checkOutput("req_ready_busy", 32'(bus.req_ready), 32'(0));
                if (prev_wait) begin
                    checkOutput("rsp_stable", 32'(bus.rsp_data), 32'(prev_data));
                end
                if (bus.rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        checkOutput("unexpected_rsp", 32'(1), 32'(0));
                    end else begin
                        checkOutput("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp.pop_front()));
                    end
                    prev_wait = 1'b0;
                end else begin
                    prev_wait = 1'b1;
                    prev_data = bus.rsp_data;
                end
            end else begin
                prev_wait = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [LW-1:0] layer, input logic [AW-1:0] addr,
                                 input int ack_delay, input int gap_pct, input int ready_delay,
                                 input bit seq_data, input logic [15:0] data_base, input int reset_after);
        logic [15:0]   words [DEPTH];
        logic [AW-1:0] a;
        bit            hit;
        int            n;
        hit = model_mem.exists({layer, addr});
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = seq_data ? data_base + 16'(i) : 16'($urandom);
        end
        if (hit) begin
            exp_rsp.push_back(model_mem[{layer, addr}]);
            if (model_hits < 65535) model_hits++;
        end else begin
            exp_rsp.push_back(words[0]);
            if (model_misses < 65535) model_misses++;
        end

        bus.req_layer = layer;
        bus.req_addr  = addr;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("req_ready_idle", 32'(bus.req_ready), 32'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_layer = LW'($urandom);
        bus.req_addr  = AW'($urandom);
        checkOutput("rsp_early", 32'(bus.rsp_valid), 32'(0));

        if (hit) begin
            @(posedge clk); #1;
            checkOutput("hit_latency", 32'(bus.rsp_valid), 32'(1));
            checkOutput("hit_no_sdram", 32'(bus.sdram_rd_req), 32'(0));
        end else begin
            n = 0;
            while (!bus.sdram_rd_req && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("sdram_req", 32'(bus.sdram_rd_req), 32'(1));
            checkOutput("sdram_addr", 32'(bus.sdram_rd_addr), 32'(addr));
            checkOutput("sdram_len", 32'(bus.sdram_rd_len), 32'(DEPTH));
            for (int d = 0; d < ack_delay; d++) begin
                @(posedge clk); #1;
                checkOutput("sdram_req_held", 32'(bus.sdram_rd_req), 32'(1));
            end
            bus.sdram_rd_ack = 1'b1;
            @(posedge clk); #1;
            bus.sdram_rd_ack = 1'b0;
            checkOutput("sdram_req_drop", 32'(bus.sdram_rd_req), 32'(0));
            for (int i = 0; i < DEPTH; i++) begin
                while ($urandom_range(99) < 32'(gap_pct)) begin
                    bus.sdram_rd_data = 16'($urandom);
                    @(posedge clk); #1;
                end
                bus.sdram_rd_valid = 1'b1;
                bus.sdram_rd_data  = words[i];
                a = addr + AW'(i);
                if (reset_after > 0 && i == reset_after) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    exp_rsp.delete();
                    exp_wr.delete();
                    model_hits   = 0;
                    model_misses = 0;
                    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'(1));
                    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
                    checkOutput("rst_sdram_req", 32'(bus.sdram_rd_req), 32'(0));
                    checkOutput("rst_write_en", 32'(bus.cache_write_en), 32'(0));
                    checkOutput("rst_hit_count", 32'(bus.hit_count), 32'(0));
                    checkOutput("rst_miss_count", 32'(bus.miss_count), 32'(0));
                    rst = 1'b0;
                end else if (reset_after == 0 || i < reset_after) begin
                    exp_wr.push_back('{layer: layer, addr: a, data: words[i]});
                    model_mem[{layer, a}] = words[i];
                    @(posedge clk); #1;
                end else begin
                    @(posedge clk); #1;
                end
                bus.sdram_rd_valid = 1'b0;
            end
            if (reset_after == 0) begin
                checkOutput("miss_latency", 32'(bus.rsp_valid), 32'(1));
            end
        end

        if (reset_after == 0) begin
            checkOutput("hit_count", 32'(bus.hit_count), 32'(model_hits));
            checkOutput("miss_count", 32'(bus.miss_count), 32'(model_misses));
            for (int d = 0; d < ready_delay; d++) begin
                @(posedge clk); #1;
            end
            bus.rsp_ready = 1'b1;
            n = 0;
            while (!bus.rsp_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            checkOutput("rsp_done", 32'(bus.rsp_valid), 32'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [LW-1:0] lay;
        logic [AW-1:0] adr;
        int            sel;
        bus.req_valid      = 1'b0;
        bus.req_layer      = '0;
        bus.req_addr       = '0;
        bus.rsp_ready      = 1'b0;
        bus.sdram_rd_ack   = 1'b0;
        bus.sdram_rd_valid = 1'b0;
        bus.sdram_rd_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'(1));
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        checkOutput("reset_sdram_req", 32'(bus.sdram_rd_req), 32'(0));
        checkOutput("reset_write_en", 32'(bus.cache_write_en), 32'(0));
        checkOutput("reset_len", 32'(bus.sdram_rd_len), 32'(DEPTH));
        checkOutput("reset_hits", 32'(bus.hit_count), 32'(0));
        checkOutput("reset_misses", 32'(bus.miss_count), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        cache_mem[{5'd2, 24'h000040}] = 16'h1234;
        model_mem[{5'd2, 24'h000040}] = 16'h1234;
        applyStimulus(5'd2, 24'h000040, 0, 0, 0, 1'b0, 16'h0, 0);
        applyStimulus(5'd3, 24'h000100, 2, 0, 0, 1'b1, 16'hA000, 0);
        applyStimulus(5'd1, 24'hFFFFF0, 1, 0, 0, 1'b0, 16'h0, 0);
        applyStimulus(5'd3, 24'h000105, 0, 0, 2, 1'b0, 16'h0, 0);
        applyStimulus(5'd1, 24'h000003, 0, 0, 1, 1'b0, 16'h0, 0);
        applyStimulus(5'd5, 24'h002000, 3, 50, 5, 1'b0, 16'h0, 0);

        for (int t = 0; t < 30; t++) begin
            lay = LW'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 2));
            if (sel == 0) adr = 24'h000100 + AW'($urandom_range(0, 40));
            else if (sel == 1) adr = AW'($urandom);
            else adr = 24'hFFFFF0 + AW'($urandom_range(0, 31));
            applyStimulus(lay, adr, int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
                          int'($urandom_range(0, 4)), 1'b0, 16'h0, 0);
        end

        applyStimulus(5'd7, 24'h300000, 1, 0, 0, 1'b0, 16'h0, 10);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(5'd7, 24'h300010, 1, 20, 2, 1'b0, 16'h0, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rsp_queue_empty", 32'(exp_rsp.size()), 32'(0));
        checkOutput("wr_queue_empty", 32'(exp_wr.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
